datapath_issue: RTL and testbench
=================================

Name: datapath_issue

Overview:
Instruction issue sequencer that drives the control/operand-select side of the datapath (op, form, vec, A, B, C, D, zero_reg, write). Accepts packed 24-bit instruction words over a valid/ready handshake and expands vector instructions into per-lane beats, one beat per cycle. Sits between instruction fetch and the datapath. All datapath-facing outputs are registered.

Parameters:
ZERO_REG, 0, 4-bit register index driven constantly on zero_reg; never treated as a hazard source.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
ins  input  24  instruction: op[23:21], form[20], vec[19:18], write[17:16], A[15:12], B[11:8], C[7:4], D[3:0]
ins_valid  input  1  ins holds a valid instruction
ins_ready  output  1  sequencer accepts ins this cycle
op  output  3  datapath opcode
form  output  1  datapath form select
vec  output  2  vec field of the instruction being issued
A  output  4  destination index for Y1 (current lane)
B  output  4  source index (current lane)
C  output  4  source index (current lane)
D  output  4  destination index for Y2 (current lane)
zero_reg  output  4  constant ZERO_REG
write  output  2  write[0] commits Y1 to A, write[1] commits Y2 to D; beat qualifier
busy  output  1  high while an instruction is being issued (including bubbles)

Behaviour:
- Reset (async, rst=1): op=0, form=0, vec=0, A=B=C=D=0, write=0, busy=0, state IDLE, held instruction discarded. Reset mid-vector drops the remaining beats; no further beats after release.
- Handshake: transfer when ins_valid && ins_ready at a rising edge. ins_ready is combinational: 1 in IDLE; 1 in ISSUE when the current cycle issues the final beat and no bubble is pending; 0 otherwise (including in BUBBLE). While ins_ready=0, ins is ignored.
- Beat count = vec+1 (1..4 beats). Beat k (k=0..vec) drives A+k, B+k, C+k, D+k, each modulo 16 (wraps 15->0). op, form, vec, write are constant across the beats of one instruction.
- Latency: instruction accepted at edge N appears as beat 0 on the outputs after edge N. One beat per cycle; back-to-back instructions issue with no gap.
- write=2'b00 instructions still consume vec+1 beat slots (NOP beats); busy stays high.
- Outputs other than write hold their last values when idle; write=0 whenever no beat is issuing. Consumers qualify only on write.
- States: IDLE -> ISSUE on accept. ISSUE -> ISSUE on a non-final beat, or on the final beat with a new accept. ISSUE -> IDLE on the final beat with no accept. ISSUE <-> BUBBLE only when DATAPATH_ISSUE_HAZARD_EN is defined.
- busy = (state != IDLE), registered.

Optional Feature:
DATAPATH_ISSUE_HAZARD_EN
- Defined: track the destinations written by the previous issued beat (A if write[0], D if write[1]). If the next beat's B or C equals one of those destinations and is not ZERO_REG, insert exactly one bubble cycle first.
  - Bubble cycle: write=0, op=0, busy=1, ins_ready=0, beat index not advanced.
  - The bubble clears the tracked destinations, so at most one bubble precedes any beat.
  - The check applies both within a vector and across instruction boundaries.
- Undefined: no check, no bubbles, and the BUBBLE state is absent.

Test Plan:
1. Reset: assert rst mid-cycle with ins_valid=1 -> all outputs 0 immediately, ins_ready=1 after release, no write until a new accept.
2. Scalar: ins with op=3, form=1, vec=0, write=01, A=2, B=4, C=5, D=6 -> one cycle later exactly one beat with write=01, A=2, B=4, C=5, D=6; then write=0 and busy=0.
3. Vector wrap: vec=3, A=14, B=0, C=8, D=15, write=11 -> four beats with A=14,15,0,1 and D=15,0,1,2; ins_ready=1 only in beat 3.
4. Back-to-back: second instruction held valid during the first's final beat -> its beat 0 issues on the very next cycle, with no write=0 gap.
5. Hazard (macro defined): instruction 1 has write=01, A=5; instruction 2 has B=5 -> one bubble cycle (write=0, ins_ready=0), then instruction 2 beat 0. Repeat with A=B=ZERO_REG -> no bubble.
6. Hazard off (macro undefined): same stimulus as scenario 5 -> no bubble; beats issue on consecutive cycles.

Source files
------------

// File: rtl/datapath_issue.sv
// ---------------------------------------------------------------------------
// datapath_issue
//
// Instruction issue sequencer feeding the control/operand-select side of the
// datapath. Packed 24-bit instructions arrive over a valid/ready handshake.
// Each instruction expands into vec+1 beats, issued one per cycle. Beat k
// presents register indices A+k, B+k, C+k, D+k (mod 16). All
// datapath-facing outputs are registered.
//
// Optional feature (macro DATAPATH_ISSUE_HAZARD_EN):
//   When defined, a beat whose B or C source matches a destination written
//   by the immediately preceding beat is delayed by one bubble cycle.
//   ZERO_REG is never treated as a hazard source. When undefined, the
//   BUBBLE state does not exist.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   ins[23:0]  in   op[23:21] form[20] vec[19:18] write[17:16]
//                   A[15:12] B[11:8] C[7:4] D[3:0]
//   ins_valid  in   ins holds a valid instruction
//   ins_ready  out  ins is accepted this cycle (combinational)
//   op/form/vec out datapath opcode, form select, vec of issuing instr
//   A/B/C/D    out  per-lane register indices
//   zero_reg   out  constant ZERO_REG
//   write      out  beat qualifier; [0] commits Y1->A, [1] commits Y2->D
//   busy       out  high while an instruction (or bubble) is in flight
//
// state  | meaning
// IDLE   | nothing issuing, ready for a new instruction
// ISSUE  | outputs hold beat beat_q of the held instruction
// BUBBLE | one dead cycle before beat beat_q (hazard build only)
// ---------------------------------------------------------------------------
module datapath_issue #(
  parameter logic [3:0] ZERO_REG = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] ins,
  input  logic        ins_valid,
  output logic        ins_ready,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  zero_reg,
  output logic [1:0]  write,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1
`ifdef DATAPATH_ISSUE_HAZARD_EN
    ,
    S_BUBBLE = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] held_q, held_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  op_q, op_d;
  logic        form_q, form_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [1:0]  write_q, write_d;
  logic        busy_q, busy_d;

  logic        last_beat;
  logic        accept;
  logic        from_new;
  logic [23:0] src;
  logic [1:0]  idx;
  logic [3:0]  nb_b, nb_c;
  logic        hazard;

  assign last_beat = (beat_q == held_q[19:18]);
  assign ins_ready = (state_q == S_IDLE) || ((state_q == S_ISSUE) && last_beat);
  assign accept    = ins_valid && ins_ready;

  // The next beat comes from the incoming word whenever the sequencer is
  // ready; otherwise it is the following (or pending) beat of the held word.
  assign from_new = ins_ready;
  assign src      = from_new ? ins : held_q;
  assign idx      = from_new ? 2'd0 :
                    ((state_q == S_ISSUE) ? beat_q + 2'd1 : beat_q);
  assign nb_b     = src[11:8] + {2'b00, idx};
  assign nb_c     = src[7:4]  + {2'b00, idx};

`ifdef DATAPATH_ISSUE_HAZARD_EN
  // Destinations of the beat currently on the outputs; write_q is zero in
  // IDLE and BUBBLE, which is what clears the tracking after a bubble.
  assign hazard =
    ((nb_b != ZERO_REG) && ((write_q[0] && (nb_b == a_q)) || (write_q[1] && (nb_b == d_q)))) ||
    ((nb_c != ZERO_REG) && ((write_q[0] && (nb_c == a_q)) || (write_q[1] && (nb_c == d_q))));
`else
  assign hazard = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!last_beat || accept) begin
`ifdef DATAPATH_ISSUE_HAZARD_EN
          state_d = hazard ? S_BUBBLE : S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef DATAPATH_ISSUE_HAZARD_EN
      S_BUBBLE: state_d = S_ISSUE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    held_d  = held_q;
    beat_d  = beat_q;
    op_d    = op_q;
    form_d  = form_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    write_d = 2'b00;
    busy_d  = (state_d != S_IDLE);

    if (accept) held_d = ins;

    if (state_d == S_ISSUE) begin
      op_d    = src[23:21];
      form_d  = src[20];
      vec_d   = src[19:18];
      write_d = src[17:16];
      a_d     = src[15:12] + {2'b00, idx};
      b_d     = nb_b;
      c_d     = nb_c;
      d_d     = src[3:0] + {2'b00, idx};
      beat_d  = idx;
    end
`ifdef DATAPATH_ISSUE_HAZARD_EN
    else if (state_d == S_BUBBLE) begin
      // Remember which beat is waiting; it issues from the held word next.
      op_d   = 3'd0;
      beat_d = idx;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q  <= '0;
      beat_q  <= '0;
      op_q    <= '0;
      form_q  <= 1'b0;
      vec_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      write_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      held_q  <= held_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      form_q  <= form_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      write_q <= write_d;
      busy_q  <= busy_d;
    end
  end

  assign op       = op_q;
  assign form     = form_q;
  assign vec      = vec_q;
  assign A        = a_q;
  assign B        = b_q;
  assign C        = c_q;
  assign D        = d_q;
  assign zero_reg = ZERO_REG;
  assign write    = write_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_datapath_issue.sv
// ---------------------------------------------------------------------------
// tb_datapath_issue
//
// Directed scenarios (reset, scalar, vector wrap, back-to-back, hazard) with
// literal expectations, followed by a randomized run checked cycle by cycle
// against a queue-based model of the issue rules. Follows the
// DATAPATH_ISSUE_HAZARD_EN macro for the expected bubble behaviour.
// ---------------------------------------------------------------------------
module tb_datapath_issue;

  localparam logic [3:0] ZR = 4'd0;

  typedef struct packed {
    logic [2:0] op;
    logic       form;
    logic [1:0] vec;
    logic [1:0] wr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  A, B, C, D;
  logic [3:0]  zero_reg;
  logic [1:0]  write;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  datapath_issue #(.ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .op(op), .form(form), .vec(vec), .A(A), .B(B), .C(C), .D(D),
    .zero_reg(zero_reg), .write(write), .busy(busy)
  );

  function automatic logic [23:0] mk(int o, int f, int v, int w, int a, int b, int c, int d);
    return {3'(o), 1'(f), 2'(v), 2'(w), 4'(a), 4'(b), 4'(c), 4'(d)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; ins_valid = 1'b0; ins = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ins = mk(5, 1, 3, 3, 1, 2, 3, 4); ins_valid = 1'b1;
    @(posedge clk); #2;
    n_vec++; if (write !== 2'b11 || A !== 4'd1) begin n_err++;
      $display("FAIL reset_pre_beat write=%0h A=%0h exp write=3 A=1", write, A); end
    @(negedge clk); rst = 1'b1; #1;
    n_vec++; if ({op, form, vec, A, B, C, D, write, busy} !== '0) begin n_err++;
      $display("FAIL reset_outputs got %0h exp 0", {op, form, vec, A, B, C, D, write, busy}); end
    n_vec++; if (zero_reg !== ZR) begin n_err++;
      $display("FAIL zero_reg got %0h exp %0h", zero_reg, ZR); end
    @(negedge clk); ins_valid = 1'b0; rst = 1'b0; #1;
    n_vec++; if (ins_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready got %0b exp 1", ins_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      n_vec++; if (write !== 2'b00 || busy !== 1'b0) begin n_err++;
        $display("FAIL reset_no_beat cyc %0d write=%0h busy=%0b exp 0 0", i, write, busy); end
    end
  endtask

  task automatic test_scalar();
    @(posedge clk); #1;
    ins = mk(3, 1, 0, 1, 2, 4, 5, 6); ins_valid = 1'b1; #1;
    n_vec++; if (ins_ready !== 1'b1) begin n_err++;
      $display("FAIL scalar_ready_idle got %0b exp 1", ins_ready); end
    @(posedge clk); #1 ins_valid = 1'b0; #1;
    n_vec++; if ({op, form, vec, write, A, B, C, D, busy} !== {3'd3, 1'b1, 2'd0, 2'b01, 4'd2, 4'd4, 4'd5, 4'd6, 1'b1}) begin
      n_err++; $display("FAIL scalar_beat got %0h exp %0h", {op, form, vec, write, A, B, C, D, busy},
                        {3'd3, 1'b1, 2'd0, 2'b01, 4'd2, 4'd4, 4'd5, 4'd6, 1'b1}); end
    @(posedge clk); #2;
    n_vec++; if (write !== 2'b00 || busy !== 1'b0 || A !== 4'd2) begin n_err++;
      $display("FAIL scalar_after write=%0h busy=%0b A=%0h exp 0 0 2", write, busy, A); end
  endtask

  task automatic test_vector_wrap();
    logic [3:0] ea, eb, ec, ed;
    @(posedge clk); #1;
    ins = mk(5, 0, 3, 3, 14, 0, 8, 15); ins_valid = 1'b1;
    @(posedge clk); #1 ins_valid = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      ea = 4'(14 + k); eb = 4'(k); ec = 4'(8 + k); ed = 4'(15 + k);
      n_vec++; if ({A, B, C, D, write, ins_ready} !== {ea, eb, ec, ed, 2'b11, 1'(k == 3)}) begin n_err++;
        $display("FAIL vec_beat%0d got A%0h B%0h C%0h D%0h w%0h r%0b exp A%0h B%0h C%0h D%0h w3 r%0b",
                 k, A, B, C, D, write, ins_ready, ea, eb, ec, ed, k == 3); end
      @(posedge clk); #2;
    end
    n_vec++; if (write !== 2'b00) begin n_err++;
      $display("FAIL vec_end write=%0h exp 0", write); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    ins = mk(1, 0, 1, 1, 1, 2, 3, 4); ins_valid = 1'b1;
    @(posedge clk); #1;
    ins = mk(2, 1, 0, 2, 7, 8, 9, 10); #1;
    n_vec++; if (ins_ready !== 1'b0 || A !== 4'd1) begin n_err++;
      $display("FAIL b2b_beat0 ready=%0b A=%0h exp 0 1", ins_ready, A); end
    @(posedge clk); #2;
    n_vec++; if (ins_ready !== 1'b1 || A !== 4'd2 || write !== 2'b01) begin n_err++;
      $display("FAIL b2b_beat1 ready=%0b A=%0h w=%0h exp 1 2 1", ins_ready, A, write); end
    @(posedge clk); #1 ins_valid = 1'b0; #1;
    n_vec++; if ({op, write, A, D} !== {3'd2, 2'b10, 4'd7, 4'd10}) begin n_err++;
      $display("FAIL b2b_second got op%0h w%0h A%0h D%0h exp op2 w2 A7 D10", op, write, A, D); end
    @(posedge clk); #2;
    n_vec++; if (write !== 2'b00 || busy !== 1'b0) begin n_err++;
      $display("FAIL b2b_idle w=%0h busy=%0b exp 0 0", write, busy); end
  endtask

  task automatic test_hazard();
    logic [23:0] i1, i2;
    logic [3:0]  eb;
    for (int t = 0; t < 2; t++) begin
      i1 = (t == 0) ? mk(1, 0, 0, 1, 5, 1, 2, 3) : mk(1, 0, 0, 1, 0, 1, 2, 3);
      i2 = (t == 0) ? mk(4, 0, 0, 1, 6, 5, 7, 8) : mk(4, 0, 0, 1, 6, 0, 7, 8);
      eb = (t == 0) ? 4'd5 : 4'd0;
      @(posedge clk); #1;
      ins = i1; ins_valid = 1'b1;
      @(posedge clk); #1;
      ins = i2; #1;
      n_vec++; if (ins_ready !== 1'b1) begin n_err++;
        $display("FAIL hz%0d_ready_final got %0b exp 1", t, ins_ready); end
      @(posedge clk); #1 ins_valid = 1'b0; #1;
`ifdef DATAPATH_ISSUE_HAZARD_EN
      if (t == 0) begin
        n_vec++; if ({write, op, busy, ins_ready} !== {2'b00, 3'd0, 1'b1, 1'b0}) begin n_err++;
          $display("FAIL hz_bubble got w%0h op%0h busy%0b r%0b exp w0 op0 busy1 r0", write, op, busy, ins_ready); end
        @(posedge clk); #2;
      end
`endif
      n_vec++; if ({write, op, B} !== {2'b01, 3'd4, eb}) begin n_err++;
        $display("FAIL hz%0d_second got w%0h op%0h B%0h exp w1 op4 B%0h", t, write, op, B, eb); end
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic test_random();
    beat_t rem[$];
    beat_t cur, cand, nb;
    logic  m_bub, m_busy, exp_rdy, haz;
    rst = 1'b1; ins_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    cur = '0; m_bub = 1'b0; m_busy = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ins_valid = ($urandom_range(0, 99) < 70);
      ins = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      #1;
      exp_rdy = (rem.size() == 0) && !m_bub;
      n_vec++; if (ins_ready !== exp_rdy) begin n_err++;
        $display("FAIL rnd_ready cyc %0d got %0b exp %0b", cyc, ins_ready, exp_rdy); end
      n_vec++; if ({op, form, vec, write, A, B, C, D} !== cur || busy !== m_busy) begin n_err++;
        $display("FAIL rnd_out cyc %0d got %0h busy %0b exp %0h busy %0b",
                 cyc, {op, form, vec, write, A, B, C, D}, busy, cur, m_busy); end
      if (ins_valid && exp_rdy) begin
        for (int k = 0; k <= int'(ins[19:18]); k++) begin
          nb   = ins;
          nb.a = ins[15:12] + 4'(k);
          nb.b = ins[11:8]  + 4'(k);
          nb.c = ins[7:4]   + 4'(k);
          nb.d = ins[3:0]   + 4'(k);
          rem.push_back(nb);
        end
      end
      if (rem.size() != 0) begin
        cand = rem[0];
`ifdef DATAPATH_ISSUE_HAZARD_EN
        haz = ((cand.b != ZR) && ((cur.wr[0] && cand.b == cur.a) || (cur.wr[1] && cand.b == cur.d))) ||
              ((cand.c != ZR) && ((cur.wr[0] && cand.c == cur.a) || (cur.wr[1] && cand.c == cur.d)));
`else
        haz = 1'b0;
`endif
        m_busy = 1'b1;
        if (haz) begin
          m_bub = 1'b1; cur.op = 3'd0; cur.wr = 2'b00;
        end else begin
          m_bub = 1'b0; cur = rem.pop_front();
        end
      end else begin
        m_bub = 1'b0; m_busy = 1'b0; cur.wr = 2'b00;
      end
      @(posedge clk); #1;
    end
    ins_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vector_wrap();
    test_back_to_back();
    test_hazard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
